// File: rtl/muldiv_pkg.sv
// Shared types and constants for the Execute-stage RV32M multiply/divide unit.
package muldiv_pkg;

    // funct3 encoding of the M-extension operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M multiply/divide unit. One 64-bit accumulator is shared:
// multiply keeps {partial_hi, multiplier}, divide keeps {remainder, quotient}.
// Signed ops work on magnitudes; the sign is restored in FIN.
module execute_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_o
);

    muldiv_state_e   state_q, state_d;
    muldiv_op_e      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [XLEN-1:0] opnd_q, opnd_d;       // |rs1| for multiply, |rs2| (divisor) for divide
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic            neg_q, neg_d;         // negate the selected result in FIN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    // Decode of the incoming operation
    muldiv_op_e      op_in;
    logic            is_div_in, is_rem_in, sa_in, sb_in, div0_in, ovf_in;
    logic [XLEN-1:0] mag_a, mag_b;

    // Iteration and finish datapath
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_nxt;
    logic [XLEN:0]     rem_sh, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quot, rem, fin_res;

    // Operand decode: signedness per op, magnitudes and the two special cases
    always_comb begin
        op_in     = muldiv_op_e'(op_i);
        is_div_in = op_i[2];
        is_rem_in = op_i[2] & op_i[1];
        sa_in     = 1'b0;
        sb_in     = 1'b0;
        case (op_in)
            OP_MULH, OP_DIV, OP_REM: begin
                sa_in = rs1_data_i[XLEN-1];
                sb_in = rs2_data_i[XLEN-1];
            end
            OP_MULHSU: sa_in = rs1_data_i[XLEN-1];
            default: ;
        endcase
        mag_a   = sa_in ? (~rs1_data_i + 1'b1) : rs1_data_i;
        mag_b   = sb_in ? (~rs2_data_i + 1'b1) : rs2_data_i;
        div0_in = is_div_in && (rs2_data_i == '0);
        ovf_in  = (op_in == OP_DIV || op_in == OP_REM) &&
                  (rs1_data_i == INT_MIN) && (rs2_data_i == '1);
    end

    // One shift-add step and one restoring-division step, plus the FIN fix-up
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
        rem_sh   = acc_q[2*XLEN-1:XLEN-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        div_ge   = ~div_diff[XLEN];
        div_nxt  = {(div_ge ? div_diff[XLEN-1:0] : rem_sh[XLEN-1:0]),
                    acc_q[XLEN-2:0], div_ge};
        prod_fix = neg_q ? (~acc_q + 1'b1) : acc_q;
        quot     = neg_q ? (~acc_q[XLEN-1:0] + 1'b1) : acc_q[XLEN-1:0];
        rem      = neg_q ? (~acc_q[2*XLEN-1:XLEN] + 1'b1) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                  fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU,
            OP_MULHU:                fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:         fin_res = quot;
            default:                 fin_res = rem;
        endcase
    end

    // Next-state and register updates; flush overrides everything
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rd_out_d = rd_out_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d = op_in;
                    rd_d = rd_i;
                    if (div0_in || ovf_in) begin
                        if (div0_in) result_d = is_rem_in ? rs1_data_i : DIV0_QUOT;
                        else         result_d = is_rem_in ? '0 : INT_MIN;
                        rd_out_d = rd_i;
                        state_d  = DONE;
                    end else begin
                        opnd_d  = is_div_in ? mag_b : mag_a;
                        acc_d   = {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
                        neg_d   = is_rem_in ? sa_in : (sa_in ^ sb_in);
                        cnt_d   = '1;
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                acc_d = op_q[2] ? div_nxt : mul_nxt;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIN;
            end
            FIN: begin
                result_d = fin_res;
                rd_out_d = rd_q;
                state_d  = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d  = IDLE;
            op_d     = op_q;
            rd_d     = rd_q;
            opnd_d   = opnd_q;
            acc_d    = acc_q;
            neg_d    = neg_q;
            cnt_d    = cnt_q;
            result_d = result_q;
            rd_out_d = rd_out_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            rd_q     <= '0;
            rd_out_q <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rd_out_q <= rd_out_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Stall drops in DONE so the pipeline advances on the edge that ends it
    always_comb begin
        stall_o  = (state_q == IDLE && valid_i) || state_q == BUSY || state_q == FIN;
        done_o   = (state_q == DONE) && !flush_i;
        result_o = result_q;
        rd_o     = rd_out_q;
    end

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Randomized self-checking bench for execute_muldiv_unit against an
// arithmetic reference model.
module tb_execute_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_i = '0;
    logic        flush_i = 1'b0;
    logic        stall_o, done_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int n_chk = 0;
    int n_err = 0;

    execute_muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .op_i(op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_i(rd_i),
        .flush_i(flush_i), .stall_o(stall_o), .done_o(done_o),
        .result_o(result_o), .rd_o(rd_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // RV32M semantics from plain integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int     ia, ib;
        longint sa, sb, ua, ub, p;
        ia = a; ib = b;
        sa = ia; sb = ib;
        ua = {32'b0, a}; ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op from IDLE and check latency, stall length, result and rd
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input string tag);
        int cyc, stalls, lat;
        logic got;
        lat = ref_lat(op, a, b);
        @(posedge clk);
        @(negedge clk);
        op_i = op; rs1_data_i = a; rs2_data_i = b; rd_i = rd; valid_i = 1'b1;
        #1;
        stalls = stall_o ? 1 : 0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
            if (done_o) got = 1'b1;
            else if (stall_o) stalls++;
        end
        valid_i = 1'b0;
        chk({tag, " latency"}, cyc, lat);
        chk({tag, " stall"}, stalls, lat);
        chk({tag, " result"}, result_o, ref_model(op, a, b));
        chk({tag, " rd"}, {27'b0, rd_o}, {27'b0, rd});
    endtask

    initial begin
        logic [31:0] saved, a, b;
        logic [2:0]  op;
        int pulses, first_at, second_at, mode;

        // reset state
        #12;
        chk("rst stall", {31'b0, stall_o}, 0);
        chk("rst done", {31'b0, done_o}, 0);
        chk("rst result", result_o, 0);
        chk("rst rd", {27'b0, rd_o}, 0);
        @(negedge clk); rst_n = 1'b1;

        // directed cases
        run_op(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd1, "mul");
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd2, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, "mulhsu");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, "mulhu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd5, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd6, "rem");
        run_op(3'd5, 32'd100, 32'd7, 5'd7, "divu");
        run_op(3'd7, 32'd100, 32'd7, 5'd8, "remu");
        run_op(3'd5, 32'd5, 32'd0, 5'd9, "divu0");
        run_op(3'd6, 32'd5, 32'd0, 5'd10, "rem0");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, "divovf");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, "removf");

        // random ops with a bias toward the special cases
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            mode = $urandom_range(0, 5);
            if (mode == 0) b = 0;
            else if (mode == 1) b = 32'($urandom_range(1, 20));
            else if (mode == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            run_op(op, a, b, 5'($urandom_range(0, 31)), "rand");
        end

        // flush in cycle 10 of a DIV
        saved = result_o;
        @(posedge clk); @(negedge clk);
        op_i = 3'd4; rs1_data_i = 32'd1000; rs2_data_i = 32'd3; rd_i = 5'd13; valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        #1;
        chk("flush done gated", {31'b0, done_o}, 0);
        @(posedge clk); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        chk("flush stall", {31'b0, stall_o}, 0);
        chk("flush done", {31'b0, done_o}, 0);
        chk("flush result hold", result_o, saved);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (done_o) pulses++; end
        chk("flush no done", pulses, 0);
        run_op(3'd3, 32'd3, 32'd5, 5'd14, "mulhu post flush");

        // reset during BUSY
        run_op(3'd0, 32'd6, 32'd7, 5'd15, "mul pre rst");
        @(posedge clk); @(negedge clk);
        op_i = 3'd0; rs1_data_i = 32'd9; rs2_data_i = 32'd9; rd_i = 5'd16; valid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin @(posedge clk); #1; end
        rst_n = 1'b0; valid_i = 1'b0;
        #1;
        chk("midrst stall", {31'b0, stall_o}, 0);
        chk("midrst done", {31'b0, done_o}, 0);
        chk("midrst result", result_o, 0);
        chk("midrst rd", {27'b0, rd_o}, 0);
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst stall", {31'b0, stall_o}, 0);
        chk("postrst done", {31'b0, done_o}, 0);

        // back-to-back MUL then DIV with valid_i held high
        @(posedge clk); @(negedge clk);
        op_i = 3'd0; rs1_data_i = 32'd12; rs2_data_i = 32'd11; rd_i = 5'd17; valid_i = 1'b1;
        pulses = 0; first_at = 0; second_at = 0;
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk); #1;
            if (done_o) begin
                pulses++;
                if (pulses == 1) begin
                    first_at = c;
                    chk("b2b mul result", result_o, ref_model(3'd0, 32'd12, 32'd11));
                    op_i = 3'd4; rs1_data_i = 32'hFFFF_FF9C; rs2_data_i = 32'd7; rd_i = 5'd18;
                end else if (pulses == 2) begin
                    second_at = c;
                    chk("b2b div result", result_o, ref_model(3'd4, 32'hFFFF_FF9C, 32'd7));
                    chk("b2b div rd", {27'b0, rd_o}, 32'd18);
                    valid_i = 1'b0;
                end
            end
        end
        chk("b2b pulses", pulses, 2);
        chk("b2b first at", first_at, 34);
        chk("b2b spacing", second_at - first_at, 35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
